// File: rtl/rf_wb_ctrl_pkg.sv
// rf_wb_ctrl_pkg: regfile geometry, writeback source encoding and bypass helper
package rf_wb_ctrl_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int RF_NUM = 32;
  localparam int WBCNT_W = 16;
  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_EX} wb_src_e;
  function automatic rf_data_t bypass(logic we, rf_addr_t waddr, rf_data_t wdata, rf_addr_t raddr, rf_data_t rdata);
    return (we && waddr == raddr && raddr != '0) ? wdata : rdata;
  endfunction
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: writeback requests, issue allocation, read-port and regfile write-port bundle
interface rf_wb_ctrl_if;
  import rf_wb_ctrl_pkg::*;
  logic mem_valid, mem_ready, ex_valid, ex_ready, alloc_valid;
  rf_addr_t mem_rd, ex_rd, alloc_rd, raddr1, raddr2, rf_waddr;
  rf_data_t mem_data, ex_data, rf_rdata1, rf_rdata2, rdata1, rdata2, rf_wdata;
  logic busy1, busy2, rf_we;
  logic [WBCNT_W-1:0] wb_count;
  modport slave (
    input mem_valid, mem_rd, mem_data, ex_valid, ex_rd, ex_data, alloc_valid, alloc_rd,
    input raddr1, raddr2, rf_rdata1, rf_rdata2,
    output mem_ready, ex_ready, rdata1, rdata2, busy1, busy2, rf_we, rf_waddr, rf_wdata, wb_count
  );
  modport master (
    output mem_valid, mem_rd, mem_data, ex_valid, ex_rd, ex_data, alloc_valid, alloc_rd,
    output raddr1, raddr2, rf_rdata1, rf_rdata2,
    input mem_ready, ex_ready, rdata1, rdata2, busy1, busy2, rf_we, rf_waddr, rf_wdata, wb_count
  );
endinterface

// File: rtl/rf_wb_ctrl_scoreboard.sv
// rf_scoreboard: per-register pending bits; set wins over clear, register 0 never pending
module rf_scoreboard import rf_wb_ctrl_pkg::*; (
  input  logic     clk,
  input  logic     resetn,
  input  logic     set_en,
  input  rf_addr_t set_rd,
  input  logic     clr_en,
  input  rf_addr_t clr_rd,
  input  rf_addr_t qa,
  input  rf_addr_t qb,
  output logic     busy_a,
  output logic     busy_b
);
  logic [RF_NUM-1:0] busy, busy_next;
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_rd] = 1'b0;
    if (set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (!resetn) busy <= '0;
    else busy <= busy_next;
  assign busy_a = busy[qa];
  assign busy_b = busy[qb];
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: MEM-priority writeback arbiter, registered regfile write port, bypass and pending scoreboard
module rf_wb_ctrl import rf_wb_ctrl_pkg::*; (
  input logic clk,
  input logic resetn,
  rf_wb_ctrl_if.slave bus
);
  wb_src_e src;
  rf_addr_t sel_rd, waddr;
  rf_data_t sel_data, wdata;
  logic we_q, take;
  logic [WBCNT_W-1:0] count;
  assign bus.mem_ready = resetn;
  assign bus.ex_ready = resetn & ~bus.mem_valid;
  assign src = (bus.mem_valid & bus.mem_ready) ? SRC_MEM : (bus.ex_valid & bus.ex_ready) ? SRC_EX : SRC_NONE;
  assign sel_rd = src == SRC_MEM ? bus.mem_rd : bus.ex_rd;
  assign sel_data = src == SRC_MEM ? bus.mem_data : bus.ex_data;
  assign take = src != SRC_NONE && sel_rd != '0;
  always_ff @(posedge clk)
    if (!resetn) begin
      we_q <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      count <= '0;
    end else begin
      we_q <= take;
      if (take) begin
        waddr <= sel_rd;
        wdata <= sel_data;
      end
      if (we_q && count != '1) count <= count + WBCNT_W'(1);
    end
  // Gating with resetn drops a write still in flight when reset lands on its commit edge.
  assign bus.rf_we = we_q & resetn;
  assign bus.rf_waddr = waddr;
  assign bus.rf_wdata = wdata;
  assign bus.wb_count = count;
  assign bus.rdata1 = bypass(bus.rf_we, waddr, wdata, bus.raddr1, bus.rf_rdata1);
  assign bus.rdata2 = bypass(bus.rf_we, waddr, wdata, bus.raddr2, bus.rf_rdata2);
  rf_scoreboard u_sb (
    .clk(clk), .resetn(resetn),
    .set_en(bus.alloc_valid), .set_rd(bus.alloc_rd),
    .clr_en(bus.rf_we), .clr_rd(waddr),
    .qa(bus.raddr1), .qb(bus.raddr2),
    .busy_a(bus.busy1), .busy_b(bus.busy2)
  );
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed scenarios plus random traffic against a cycle-level writeback model
module tb_rf_wb_ctrl;
  import rf_wb_ctrl_pkg::*;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} wr_t;
  logic clk = 0;
  logic resetn = 0;
  always #5 clk = ~clk;
  rf_wb_ctrl_if bus();
  rf_wb_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge clk) if (bus.rf_we && bus.rf_waddr != 0) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  assign bus.rf_rdata1 = bus.raddr1 == 0 ? 32'h0 : rf_mem[bus.raddr1];
  assign bus.rf_rdata2 = bus.raddr2 == 0 ? 32'h0 : rf_mem[bus.raddr2];
  logic [31:0] mreg [32] = '{default: 32'h0};
  logic [31:0] pend = 0;
  int unsigned cnt = 0;
  logic fl_v = 0;
  logic [4:0] fl_rd = 0;
  logic [31:0] fl_data = 0;
  wr_t q[$];
  wr_t mon_e;
  int total = 0, bad = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk1(string n, logic act, logic exp);
    chk(n, {31'b0, act}, {31'b0, exp});
  endtask
  function automatic logic [31:0] byp(logic [4:0] a);
    return (resetn && fl_v && fl_rd == a && a != 0) ? fl_data : mreg[a];
  endfunction
  // Reference: an accepted write is visible on the port next cycle and lands in the file at the edge after.
  always @(posedge clk) begin
    if (!resetn) begin
      if (fl_v) void'(q.pop_back());
      fl_v = 0;
      pend = 0;
      cnt = 0;
    end else begin
      if (fl_v) begin
        mreg[fl_rd] = fl_data;
        if (cnt < 65535) cnt++;
        pend[fl_rd] = 0;
      end
      fl_v = 0;
      if (bus.mem_valid) begin
        fl_v = bus.mem_rd != 0; fl_rd = bus.mem_rd; fl_data = bus.mem_data;
      end else if (bus.ex_valid) begin
        fl_v = bus.ex_rd != 0; fl_rd = bus.ex_rd; fl_data = bus.ex_data;
      end
      if (fl_v) q.push_back({fl_rd, fl_data});
      if (bus.alloc_valid) pend[bus.alloc_rd] = 1;
      pend[0] = 0;
    end
  end
  always @(negedge clk) begin
    chk1("mem_ready", bus.mem_ready, resetn);
    chk1("ex_ready", bus.ex_ready, resetn && !bus.mem_valid);
    chk1("rf_we", bus.rf_we, fl_v && resetn);
    chk("wb_count", {16'b0, bus.wb_count}, cnt);
    chk1("busy1", bus.busy1, pend[bus.raddr1]);
    chk1("busy2", bus.busy2, pend[bus.raddr2]);
    chk("rdata1", bus.rdata1, byp(bus.raddr1));
    chk("rdata2", bus.rdata2, byp(bus.raddr2));
  end
  always @(negedge clk) if (bus.rf_we) begin
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.rf_waddr, bus.rf_wdata);
    end else begin
      mon_e = q.pop_front();
      chk("wr_addr", {27'b0, bus.rf_waddr}, {27'b0, mon_e.rd});
      chk("wr_data", bus.rf_wdata, mon_e.d);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mem_req(logic [4:0] rd, logic [31:0] d);
    bus.mem_valid = 1; bus.mem_rd = rd; bus.mem_data = d;
  endtask
  initial begin
    logic ex_acc;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_data = 0;
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.raddr1 = 0; bus.raddr2 = 0;
    repeat (2) cyc();
    chk("rst_waddr", {27'b0, bus.rf_waddr}, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk1("rst_mem_ready", bus.mem_ready, 0);
    resetn = 1;
    bus.ex_valid = 1; bus.ex_rd = 5'h10; bus.ex_data = 32'h0000FFFF;
    cyc();
    bus.ex_valid = 0;
    chk1("ex_single_we", bus.rf_we, 1);
    cyc();
    chk("ex_single_rf16", rf_mem[16], 32'h0000FFFF);
    chk("ex_single_cnt", {16'b0, bus.wb_count}, 1);
    mem_req(5'h11, 32'h1111FFFF);
    bus.ex_valid = 1; bus.ex_rd = 5'h11; bus.ex_data = 32'h2222FFFF;
    #1 chk1("cont_ex_stall", bus.ex_ready, 0);
    cyc();
    bus.mem_valid = 0;
    #1 chk1("cont_ex_go", bus.ex_ready, 1);
    chk("cont_first", bus.rf_wdata, 32'h1111FFFF);
    cyc();
    bus.ex_valid = 0;
    chk("cont_second", bus.rf_wdata, 32'h2222FFFF);
    repeat (2) cyc();
    chk("cont_rf17", rf_mem[17], 32'h2222FFFF);
    bus.ex_valid = 1; bus.ex_rd = 0; bus.ex_data = 32'hFFFFFFFF;
    #1 chk1("x0_ready", bus.ex_ready, 1);
    cyc();
    bus.ex_valid = 0;
    chk1("x0_no_we", bus.rf_we, 0);
    cyc();
    bus.raddr1 = 0;
    #1 chk("x0_rdata", bus.rdata1, 0);
    chk("x0_cnt", {16'b0, bus.wb_count}, 3);
    mem_req(5'h12, 32'h3333FFFF);
    cyc();
    bus.mem_valid = 0; bus.raddr1 = 5'h12; bus.raddr2 = 5'h12;
    #1 chk("byp_rdata1", bus.rdata1, 32'h3333FFFF);
    chk("byp_rdata2", bus.rdata2, 32'h3333FFFF);
    cyc();
    bus.alloc_valid = 1; bus.alloc_rd = 5'h13; bus.raddr1 = 5'h13;
    cyc();
    bus.alloc_valid = 0;
    chk1("sb_set", bus.busy1, 1);
    mem_req(5'h13, 32'h44440000);
    cyc();
    bus.mem_valid = 0;
    chk1("sb_commit_cycle", bus.busy1, 1);
    cyc();
    chk1("sb_cleared", bus.busy1, 0);
    mem_req(5'h13, 32'h55550000);
    cyc();
    bus.mem_valid = 0; bus.alloc_valid = 1; bus.alloc_rd = 5'h13;
    cyc();
    bus.alloc_valid = 0;
    chk1("sb_set_wins", bus.busy1, 1);
    mem_req(5'h13, 32'h66660000);
    repeat (2) cyc();
    chk1("sb_recleared", bus.busy1, 0);
    mem_req(5'h14, 32'h77770000);
    bus.alloc_valid = 1; bus.alloc_rd = 5'h15;
    cyc();
    bus.mem_valid = 0; bus.alloc_valid = 0; resetn = 0;
    cyc();
    resetn = 1;
    chk("rst_mid_cnt", {16'b0, bus.wb_count}, 0);
    chk("rst_mid_rf20", rf_mem[20], 0);
    for (int r = 0; r < 32; r++) begin
      bus.raddr1 = 5'(r);
      #1 chk1("rst_mid_busy", bus.busy1, 0);
    end
    cyc();
    chk("rst_mid_rf20_late", rf_mem[20], 0);
    for (int i = 0; i < 3000; i++) begin
      resetn = $urandom_range(0, 199) != 0;
      bus.mem_valid = $urandom_range(0, 2) == 0;
      bus.mem_rd = 5'($urandom); bus.mem_data = $urandom;
      if (!bus.ex_valid && $urandom_range(0, 1) == 1) begin
        bus.ex_valid = 1; bus.ex_rd = 5'($urandom); bus.ex_data = $urandom;
      end
      bus.alloc_valid = $urandom_range(0, 3) == 0;
      bus.alloc_rd = 5'($urandom);
      bus.raddr1 = 5'($urandom); bus.raddr2 = 5'($urandom);
      ex_acc = resetn && bus.ex_valid && !bus.mem_valid;
      cyc();
      if (ex_acc) bus.ex_valid = 0;
    end
    resetn = 1; bus.mem_valid = 0; bus.ex_valid = 0; bus.alloc_valid = 0;
    repeat (4) cyc();
    chk("drain_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
